// File: rtl/mdiv_pkg.sv
// Shared types for the execute-stage multiplier: FSM states and Booth recode ops.
package mdiv_pkg;

  localparam int WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    NOP = 2'b00,
    ADD = 2'b01,
    SUB = 2'b10
  } booth_op_t;

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth step: recode P[1:0], add/sub M into the upper word, arithmetic shift right.
module booth_step
  import mdiv_pkg::*;
#(
  parameter int WIDTH = mdiv_pkg::WIDTH
) (
  input  logic [2*WIDTH:0] p,
  input  logic [WIDTH-1:0] m,
  output logic [2*WIDTH:0] p_nxt
);

  booth_op_t        op;
  logic [WIDTH:0]   hi;
  logic [WIDTH:0]   m_x;
  logic [WIDTH:0]   sum;

  always_comb begin
    case (p[1:0])
      2'b01:   op = ADD;
      2'b10:   op = SUB;
      default: op = NOP;
    endcase

    // One guard bit on the adder so subtracting the most negative multiplicand
    // keeps the correct sign; that sign is what the shift brings in.
    hi  = {p[2*WIDTH], p[2*WIDTH:WIDTH+1]};
    m_x = {m[WIDTH-1], m};

    case (op)
      ADD:     sum = hi + m_x;
      SUB:     sum = hi + ~m_x + (WIDTH+1)'(1);
      default: sum = hi;
    endcase

    p_nxt = {sum, p[WIDTH:1]};
  end

endmodule

// File: rtl/booth_multiplier.sv
// Iterative signed multiplier, one Booth step per clock; result returned with a one-cycle ready pulse.
module booth_multiplier
  import mdiv_pkg::*;
#(
  parameter int WIDTH = mdiv_pkg::WIDTH,
  parameter int CNT_W = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [2*WIDTH:0] p, p_nxt;
  logic [WIDTH-1:0] m;
  logic             load, step, last;
  logic [WIDTH:0]   top_bits;

  booth_step #(.WIDTH(WIDTH)) u_step (
    .p     (p),
    .m     (m),
    .p_nxt (p_nxt)
  );

  assign last     = (cnt == CNT_W'(WIDTH-1));
  assign top_bits = p_nxt[2*WIDTH:WIDTH];

  // A start pulse in any state restarts from fresh operands.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    case (state)
      IDLE: if (ctrl_MULT) load = 1'b1;
      RUN: begin
        if (ctrl_MULT) load = 1'b1;
        else           step = 1'b1;
      end
      DONE: begin
        if (ctrl_MULT) load = 1'b1;
        else           state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (load)              state_nxt = RUN;
    else if (step && last) state_nxt = DONE;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      cnt            <= '0;
      p              <= '0;
      m              <= '0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
      busy           <= 1'b0;
    end else begin
      state          <= state_nxt;
      data_resultRDY <= 1'b0;
      if (load) begin
        p    <= {{WIDTH{1'b0}}, data_operandB, 1'b0};
        m    <= data_operandA;
        cnt  <= '0;
        busy <= 1'b1;
      end else if (step) begin
        p   <= p_nxt;
        cnt <= cnt + CNT_W'(1);
        if (last) begin
          data_result    <= p_nxt[WIDTH:1];
          // Product fits only if the upper word matches the sign of the low word.
          data_exception <= !((&top_bits) || (top_bits == '0));
          data_resultRDY <= 1'b1;
          busy           <= 1'b0;
        end
      end
    end
  end

endmodule
